// File: rtl/fifo_pop_downsizer.sv
// Pops wide words from a zero-latency FIFO and emits them as narrow beats, least-significant slice first.
// The first beat appears one cycle after the pop. While i_ready is low the held beat is frozen and no pop is issued.
module fifo_pop_downsizer #(
    parameter int IN_DWIDTH  = 32,
    parameter int OUT_DWIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    output logic                  o_fifo_pop,
    input  logic                  i_fifo_empty,
    input  logic [IN_DWIDTH-1:0]  i_fifo_rdata,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [OUT_DWIDTH-1:0] o_data,
    output logic                  o_last,
    output logic                  o_busy
);
    localparam int RATIO  = IN_DWIDTH / OUT_DWIDTH;
    localparam int CWIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CWIDTH-1:0] LAST_CNT = CWIDTH'(RATIO - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                state_q, state_d;
    logic [IN_DWIDTH-1:0]  hold_q, hold_d;
    logic [CWIDTH-1:0]     cnt_q, cnt_d;
    logic                  hs;

    assign o_valid    = (state_q == SEND);
    assign o_busy     = (state_q == SEND);
    assign o_data     = hold_q[OUT_DWIDTH-1:0];
    assign o_last     = o_valid & (cnt_q == LAST_CNT);
    assign hs         = o_valid & i_ready;
    // A pop in SEND only happens as the last beat leaves, so words chain with no bubble.
    assign o_fifo_pop = !i_rst & !i_fifo_empty & ((state_q == IDLE) | (hs & o_last));

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (o_fifo_pop) begin
                hold_d  = i_fifo_rdata;
                cnt_d   = '0;
                state_d = SEND;
            end
        end else if (hs) begin
            if (!o_last) begin
                hold_d = hold_q >> OUT_DWIDTH;
                cnt_d  = cnt_q + CWIDTH'(1);
            end else if (o_fifo_pop) begin
                hold_d = i_fifo_rdata;
                cnt_d  = '0;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

`ifndef SYNTHESIS
    if (IN_DWIDTH % OUT_DWIDTH != 0) begin : g_width_check
        $error("IN_DWIDTH must be a multiple of OUT_DWIDTH");
    end

    ap_no_pop_when_empty: assert property (@(posedge i_clk) !(o_fifo_pop && i_fifo_empty));
    ap_stable_under_bp: assert property (@(posedge i_clk)
        (o_valid && !i_ready && !i_rst) |=> (o_valid && $stable(o_data) && $stable(o_last)));
    ap_cnt_range: assert property (@(posedge i_clk) cnt_q <= LAST_CNT);
`endif
endmodule
